// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 active-low key matrix one column at a time, reads the rows back
// through a 2-flop synchronizer, debounces one key and hands its code {row,col} to a consumer
// through a single-entry valid/ack buffer with a sticky overrun flag.
// Optional build macro KEYPAD_REPEAT_EN adds typematic auto-repeat while a key stays held.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV    = 65536,
  parameter int unsigned DEB_CNT     = 4,
  parameter int unsigned REPEAT_DLY  = 250,
  parameter int unsigned REPEAT_RATE = 60
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  input  logic       key_ack_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_held_o,
  output logic       overrun_o
);

  localparam int unsigned PreW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DebW = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_s1_q, rs_q;
  logic [PreW-1:0] presc_q, presc_d;
  logic [1:0]  col_idx_q;
  logic        col_on_q;
  logic [3:0]  pat_q, pat_d;
  logic [DebW-1:0] deb_q, deb_d, deb_inc;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;
  logic        overrun_q, overrun_d;

  logic        tick, rs_idle, deb_done;
  logic        emit, col_adv, held_set, held_clr;
  logic [1:0]  row_idx;
  logic [3:0]  code_new;

  assign tick     = (presc_q == PreW'(SCAN_DIV - 1));
  assign rs_idle  = (rs_q == 4'hF);
  assign deb_inc  = deb_q + DebW'(1);
  assign deb_done = (deb_inc == DebW'(DEB_CNT));
  assign presc_d  = tick ? '0 : presc_q + PreW'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  logic [RptW-1:0] rpt_q, rpt_d, rpt_inc;
  // Set once the first (long-delay) repeat has fired for the current hold.
  logic            rpt_first_q, rpt_first_d;
  assign rpt_inc = rpt_q + RptW'(1);
`else
  // Repeat timing is unused without auto-repeat.
  logic unused_rpt_cfg;
  assign unused_rpt_cfg = ^{REPEAT_DLY, REPEAT_RATE};
`endif

  // Lowest-index low row of the captured pattern selects the row part of the code.
  always_comb begin
    row_idx = 2'd3;
    if (!pat_q[0])      row_idx = 2'd0;
    else if (!pat_q[1]) row_idx = 2'd1;
    else if (!pat_q[2]) row_idx = 2'd2;
    code_new = {row_idx, col_idx_q};
  end

  // Column strobe: nothing driven until the first clock after reset.
  always_comb begin
    col_o = 4'hF;
    if (col_on_q) begin
      unique case (col_idx_q)
        2'd0:    col_o = 4'b1110;
        2'd1:    col_o = 4'b1101;
        2'd2:    col_o = 4'b1011;
        default: col_o = 4'b0111;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StScan;
    else         state_q <= state_d;
  end

  // FSM next-state: all transitions happen on the scan tick only.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        StScan:     if (!rs_idle) state_d = StDebounce;
        StDebounce: begin
          if (rs_q != pat_q) state_d = StScan;
          else if (deb_done) state_d = StPressed;
        end
        StPressed:  if (rs_idle) state_d = StRelease;
        StRelease: begin
          if (!rs_idle)      state_d = StPressed;
          else if (deb_done) state_d = StScan;
        end
        default:    state_d = StScan;
      endcase
    end
  end

  // FSM outputs: debounce bookkeeping, column advance, key events.
  always_comb begin
    pat_d    = pat_q;
    deb_d    = deb_q;
    col_adv  = 1'b0;
    emit     = 1'b0;
    held_set = 1'b0;
    held_clr = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d       = rpt_q;
    rpt_first_d = rpt_first_q;
`endif
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (rs_idle) begin
            col_adv = 1'b1;
          end else begin
            pat_d = rs_q;
            deb_d = DebW'(1);
          end
        end
        StDebounce: begin
          if (rs_q == pat_q) begin
            deb_d = deb_inc;
            if (deb_done) begin
              emit     = 1'b1;
              held_set = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rpt_d       = '0;
              rpt_first_d = 1'b0;
`endif
            end
          end
        end
        StPressed: begin
          if (rs_idle) begin
            deb_d = DebW'(1);
`ifdef KEYPAD_REPEAT_EN
            rpt_d       = '0;
            rpt_first_d = 1'b0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rpt_d = rpt_inc;
            if ((!rpt_first_q && rpt_inc == RptW'(REPEAT_DLY)) ||
                (rpt_first_q && rpt_inc == RptW'(REPEAT_RATE))) begin
              emit        = 1'b1;
              rpt_d       = '0;
              rpt_first_d = 1'b1;
            end
`endif
          end
        end
        StRelease: begin
          if (rs_idle) begin
            deb_d = deb_inc;
            if (deb_done) begin
              held_clr = 1'b1;
              col_adv  = 1'b1;
            end
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rpt_d = '0;  // bounce back to held: restart repeat timing
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Output buffer: a new event overwrites only if the slot is free or acknowledged this cycle.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    key_held_d  = key_held_q;
    if (held_set)      key_held_d = 1'b1;
    else if (held_clr) key_held_d = 1'b0;
    if (emit) begin
      if (!key_valid_q || key_ack_i) begin
        key_code_d  = code_new;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack_i && key_valid_q) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  // Datapath registers: synchronizer, prescaler, column, debounce, output buffer.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_s1_q    <= 4'hF;
      rs_q        <= 4'hF;
      presc_q     <= '0;
      col_idx_q   <= 2'd0;
      col_on_q    <= 1'b0;
      pat_q       <= 4'hF;
      deb_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      row_s1_q    <= row_i;
      rs_q        <= row_s1_q;
      presc_q     <= presc_d;
      col_idx_q   <= col_idx_q + {1'b0, col_adv};
      col_on_q    <= 1'b1;
      pat_q       <= pat_d;
      deb_q       <= deb_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  // Auto-repeat counters.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rpt_q       <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign key_held_o  = key_held_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 key-matrix model.
module tb_keypad_scanner;

`ifdef KEYPAD_REPEAT_EN
  localparam logic RptEn = 1'b1;
`else
  localparam logic RptEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [3:0] row_i;
  logic [3:0] col_o;
  logic       key_ack_i;
  logic [3:0] key_code_o;
  logic       key_valid_o;
  logic       key_held_o;
  logic       overrun_o;

  // Key matrix model.
  logic       key_down;
  logic [1:0] key_r, key_c;
  logic       ovr_en;
  logic [3:0] ovr_row;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  always #5 clk_i = ~clk_i;

  always_comb begin
    row_i = 4'hF;
    if (ovr_en) row_i = ovr_row;
    else if (key_down && col_o[key_c] == 1'b0) row_i[key_r] = 1'b0;
  end

  keypad_scanner #(
    .SCAN_DIV   (4),
    .DEB_CNT    (3),
    .REPEAT_DLY (5),
    .REPEAT_RATE(2)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .row_i      (row_i),
    .col_o      (col_o),
    .key_ack_i  (key_ack_i),
    .key_code_o (key_code_o),
    .key_valid_o(key_valid_o),
    .key_held_o (key_held_o),
    .overrun_o  (overrun_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance to just after edge n (edge 0 is the first edge after reset release).
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r    = r;
    key_c    = c;
    key_down = 1'b1;
  endtask

  initial begin
    logic [3:0] exp_col;
    rst_ni    = 1'b0;
    key_ack_i = 1'b0;
    key_down  = 1'b0;
    key_r     = 2'd0;
    key_c     = 2'd0;
    ovr_en    = 1'b0;
    ovr_row   = 4'hF;
    cyc       = 0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_col", col_o, 4'hF);
    check_eq("rst_valid", key_valid_o, 1'b0);
    check_eq("rst_held", key_held_o, 1'b0);
    check_eq("rst_overrun", overrun_o, 1'b0);
    check_eq("rst_code", key_code_o, 4'h0);
    rst_ni = 1'b1;
    cyc    = -1;

    // 1: idle scan, column rotates every 4 clocks (first dwell is 3 after release).
    for (int k = 0; k < 40; k++) begin
      step_to(k);
      exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
      check_eq("idle_col", col_o, exp_col);
      check_eq("idle_valid", key_valid_o, 1'b0);
    end

    // 2: key 9 (row2, col1) clean press, ack, release.
    press(2'd2, 2'd1);
    step_to(62);
    check_eq("k9_pre_valid", key_valid_o, 1'b0);
    step_to(63);
    check_eq("k9_valid", key_valid_o, 1'b1);
    check_eq("k9_code", key_code_o, 4'd9);
    check_eq("k9_held", key_held_o, 1'b1);
    step_to(67);
    check_eq("k9_col_frozen", col_o, 4'b1101);
    step_to(68);
    key_ack_i = 1'b1;
    step_to(69);
    key_ack_i = 1'b0;
    check_eq("k9_ack_valid", key_valid_o, 1'b0);
    check_eq("k9_ack_overrun", overrun_o, 1'b0);
    key_down = 1'b0;
    step_to(82);
    check_eq("k9_rel_held_pre", key_held_o, 1'b1);
    step_to(83);
    check_eq("k9_rel_held", key_held_o, 1'b0);
    check_eq("k9_rel_col", col_o, 4'b1011);

    // 3: one-tick bounce on row0 at column 0 rescans the same column.
    step_to(91);
    check_eq("bnc_col0", col_o, 4'b1110);
    step_to(92);
    ovr_en  = 1'b1;
    ovr_row = 4'b1110;
    step_to(95);
    check_eq("bnc_frozen", col_o, 4'b1110);
    ovr_en = 1'b0;
    step_to(99);
    check_eq("bnc_rescan", col_o, 4'b1110);
    step_to(103);
    check_eq("bnc_resume", col_o, 4'b1101);
    check_eq("bnc_valid", key_valid_o, 1'b0);

    // 4: unacknowledged key 9, then key 0 -> overrun, code kept.
    press(2'd2, 2'd1);
    step_to(114);
    check_eq("ov_pre_valid", key_valid_o, 1'b0);
    step_to(115);
    check_eq("ov_k9_valid", key_valid_o, 1'b1);
    check_eq("ov_k9_code", key_code_o, 4'd9);
    key_down = 1'b0;
    step_to(127);
    check_eq("ov_k9_released", key_held_o, 1'b0);
    press(2'd0, 2'd0);
    step_to(146);
    check_eq("ov_pre_overrun", overrun_o, 1'b0);
    step_to(147);
    check_eq("ov_valid", key_valid_o, 1'b1);
    check_eq("ov_code", key_code_o, 4'd9);
    check_eq("ov_flag", overrun_o, 1'b1);
    check_eq("ov_held", key_held_o, 1'b1);
    key_ack_i = 1'b1;
    step_to(148);
    key_ack_i = 1'b0;
    check_eq("ov_ack_valid", key_valid_o, 1'b0);
    check_eq("ov_ack_flag", overrun_o, 1'b0);

    // 5: key 5, reset in the middle of debounce, re-detected afterwards.
    step_to(149);
    key_down = 1'b0;
    step_to(163);
    check_eq("r5_rel_held", key_held_o, 1'b0);
    check_eq("r5_rel_col", col_o, 4'b1101);
    press(2'd1, 2'd1);
    step_to(170);
    rst_ni = 1'b0;
    step_to(171);
    rst_ni = 1'b1;
    check_eq("r5_rst_col", col_o, 4'hF);
    check_eq("r5_rst_valid", key_valid_o, 1'b0);
    check_eq("r5_rst_held", key_held_o, 1'b0);
    check_eq("r5_rst_code", key_code_o, 4'h0);
    step_to(174);
    check_eq("r5_col0", col_o, 4'b1110);
    step_to(175);
    check_eq("r5_col1", col_o, 4'b1101);
    step_to(186);
    check_eq("r5_pre_valid", key_valid_o, 1'b0);
    step_to(187);
    check_eq("r5_valid", key_valid_o, 1'b1);
    check_eq("r5_code", key_code_o, 4'd5);
    check_eq("r5_held", key_held_o, 1'b1);
    key_ack_i = 1'b1;
    step_to(188);
    key_ack_i = 1'b0;
    check_eq("r5_ack_valid", key_valid_o, 1'b0);

    // 6: keep key 5 held; repeats at +5 ticks then every 2 ticks only with auto-repeat.
    for (int i = 0; i < 3; i++) begin
      int p;
      p = (i == 0) ? 207 : ((i == 1) ? 215 : 223);
      step_to(p - 1);
      check_eq("rpt_pre_valid", key_valid_o, 1'b0);
      step_to(p);
      check_eq("rpt_valid", key_valid_o, RptEn);
      check_eq("rpt_held", key_held_o, 1'b1);
      check_eq("rpt_overrun", overrun_o, 1'b0);
      if (RptEn) check_eq("rpt_code", key_code_o, 4'd5);
      key_ack_i = 1'b1;
      step_to(p + 1);
      key_ack_i = 1'b0;
      check_eq("rpt_ack_valid", key_valid_o, 1'b0);
    end
    step_to(224);
    key_down = 1'b0;
    step_to(240);
    check_eq("end_held", key_held_o, 1'b0);
    check_eq("end_valid", key_valid_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
